// File: rtl/mips_dmem_mmio_if.sv
// Data-port bus between the single-cycle MIPS core and its data-side responder.
//   memwrite     : write strobe from the core
//   memaddr      : byte address (bits [1:0] ignored by the responder)
//   memwritedata : write data
//   memreaddata  : combinational read data returned to the core
interface mips_dmem_mmio_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;

  modport master (
    output memwrite,
    output memaddr,
    output memwritedata,
    input  memreaddata
  );

  modport slave (
    input  memwrite,
    input  memaddr,
    input  memwritedata,
    output memreaddata
  );
endinterface

// File: rtl/mips_dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: word-addressed RAM,
// LED register, synchronized switch input and a prescaled timer with
// compare match and level interrupt.
//   clk      : core clock, all state updates on the rising edge
//   reset    : asynchronous, active-high reset
//   bus      : core data port (slave side), read data is combinational
//   switches : asynchronous board inputs
//   leds     : LED register output
//   irq      : timer interrupt, flag & ie
// Map (word compare on memaddr[31:2]):
//   0x0000_0000.. RAM, FFFF_0000 LED, FFFF_0004 SW, FFFF_0008 COUNT,
//   FFFF_000C COMPARE, FFFF_0010 CTRL {ie,autoreload,en}, FFFF_0014 STATUS {flag,-}
module mips_dmem_mmio #(
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_dmem_mmio_if.slave        bus,
  input  logic [7:0]             switches,
  output logic [7:0]             leds,
  output logic                   irq
);

  localparam logic [29:0] A_LED     = 30'h3FFF_C000;
  localparam logic [29:0] A_SW      = 30'h3FFF_C001;
  localparam logic [29:0] A_COUNT   = 30'h3FFF_C002;
  localparam logic [29:0] A_COMPARE = 30'h3FFF_C003;
  localparam logic [29:0] A_CTRL    = 30'h3FFF_C004;
  localparam logic [29:0] A_STATUS  = 30'h3FFF_C005;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [31:0]       r_ram [0:(1 << RAM_AW) - 1];
  logic [7:0]        r_led;
  logic [7:0]        r_sync1;
  logic [7:0]        r_sync2;
  logic [31:0]       r_count;
  logic [31:0]       r_compare;
  logic              r_en;
  logic              r_autoreload;
  logic              r_ie;
  logic              r_flag;
  logic [15:0]       r_presc;

  logic [29:0]       w_word;
  logic              w_ram_hit;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_led;
  logic              w_wr_count;
  logic              w_wr_compare;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_tick;
  logic              w_match;
  logic [31:0]       w_rdata;

  assign w_word    = bus.memaddr[31:2];
  assign w_ram_hit = (bus.memaddr[31:RAM_AW+2] == '0);
  assign w_ram_idx = bus.memaddr[RAM_AW+1:2];

  assign w_wr_led     = bus.memwrite && (w_word == A_LED);
  assign w_wr_count   = bus.memwrite && (w_word == A_COUNT);
  assign w_wr_compare = bus.memwrite && (w_word == A_COMPARE);
  assign w_wr_ctrl    = bus.memwrite && (w_word == A_CTRL);
  assign w_wr_status  = bus.memwrite && (w_word == A_STATUS);

  // Tick and match are evaluated on pre-edge state, so a same-cycle CPU
  // write to COUNT or CTRL still sees the old values for this tick.
  assign w_tick  = r_en && (r_presc == PRESC_LAST);
  assign w_match = (r_count == r_compare);

  // RAM has no reset; contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (bus.memwrite && w_ram_hit) begin
      r_ram[w_ram_idx] <= bus.memwritedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= bus.memwritedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en         <= 1'b0;
      r_autoreload <= 1'b0;
      r_ie         <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en         <= bus.memwritedata[0];
      r_autoreload <= bus.memwritedata[1];
      r_ie         <= bus.memwritedata[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (!r_en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_compare <= '1;
    end else if (w_wr_compare) begin
      r_compare <= bus.memwritedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= bus.memwritedata;
    end else if (w_tick) begin
      if (w_match && r_autoreload) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  // Set by a matching tick takes priority over a same-cycle write-1-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (w_tick && w_match) begin
      r_flag <= 1'b1;
    end else if (w_wr_status && bus.memwritedata[1]) begin
      r_flag <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_word)
        A_LED:     w_rdata = {24'd0, r_led};
        A_SW:      w_rdata = {24'd0, r_sync2};
        A_COUNT:   w_rdata = r_count;
        A_COMPARE: w_rdata = r_compare;
        A_CTRL:    w_rdata = {29'd0, r_ie, r_autoreload, r_en};
        A_STATUS:  w_rdata = {30'd0, r_flag, 1'b0};
        default:   w_rdata = '0;
      endcase
    end
  end

  assign bus.memreaddata = w_rdata;
  assign leds            = r_led;
  assign irq             = r_flag & r_ie;

endmodule

// File: tb/tb_mips_dmem_mmio.sv
module tb_mips_dmem_mmio;

  localparam logic [31:0] A_LED     = 32'hFFFF_0000;
  localparam logic [31:0] A_SW      = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT   = 32'hFFFF_0008;
  localparam logic [31:0] A_COMPARE = 32'hFFFF_000C;
  localparam logic [31:0] A_CTRL    = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0014;

  logic       clk;
  logic       reset;
  logic [7:0] switches;
  logic [7:0] leds;
  logic       irq;

  int checks;
  int failures;

  mips_dmem_mmio_if bus();

  mips_dmem_mmio #(
    .RAM_AW  (6),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .switches(switches),
    .leds    (leds),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite     = 1'b1;
    bus.memaddr      = a;
    bus.memwritedata = d;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
    bus.memwrite = 1'b0;
    bus.memaddr  = a;
    #1;
    chk(name, bus.memreaddata, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    switches         = 8'h00;
    bus.memwrite     = 1'b0;
    bus.memaddr      = 32'h0;
    bus.memwritedata = 32'h0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1111_1111};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h1234_5678};
    vecs[11] = '{1'b1, A_LED,         32'hFFFF_FFA5, 1'b1, 32'h0};
    vecs[12] = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_00A5};
    vecs[13] = '{1'b0, A_COUNT,       32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b0, A_COMPARE,     32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[15] = '{1'b1, A_CTRL,        32'hFFFF_FFF2, 1'b1, 32'h0};
    vecs[16] = '{1'b0, A_CTRL,        32'h0,         1'b1, 32'h0000_0002};
    vecs[17] = '{1'b1, A_CTRL,        32'h0,         1'b1, 32'h0000_0002};
    vecs[18] = '{1'b1, A_SW,          32'h0000_0055, 1'b1, 32'h0};
    vecs[19] = '{1'b0, A_SW,          32'h0,         1'b1, 32'h0};
    vecs[20] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0};
    vecs[21] = '{1'b0, 32'hFFFF_0018, 32'h0,         1'b1, 32'h0};
    vecs[22] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[23] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

    // Reset state while reset is held
    #12;
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rd_chk("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
    reset = 1'b0;
    step(1);

    // Table-driven bus accesses, read value sampled before the edge
    for (int i = 0; i < NV; i++) begin
      bus.memwrite     = vecs[i].we;
      bus.memaddr      = vecs[i].addr;
      bus.memwritedata = vecs[i].wdata;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d", i), bus.memreaddata, vecs[i].exp);
      @(posedge clk);
      #1;
      bus.memwrite = 1'b0;
    end
    chk("leds_a5", {24'd0, leds}, 32'h0000_00A5);

    // Switch synchronizer: visible after two edges
    switches = 8'h3C;
    rd_chk("sw_edge0", A_SW, 32'h0);
    step(1);
    rd_chk("sw_edge1", A_SW, 32'h0);
    step(1);
    rd_chk("sw_edge2", A_SW, 32'h0000_003C);

    // One-shot timer, COMPARE=3, CTRL=en|ie
    wr(A_COMPARE, 32'd3);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      rd_chk($sformatf("oneshot_count_e%0d", i), A_COUNT, 32'(i / 4));
      chk($sformatf("oneshot_irq_e%0d", i), {31'd0, irq}, (i >= 16) ? 32'd1 : 32'd0);
    end
    rd_chk("oneshot_status", A_STATUS, 32'h2);
    wr(A_CTRL, 32'h1);
    chk("ie_off_irq", {31'd0, irq}, 32'h0);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h2);
    rd_chk("status_cleared", A_STATUS, 32'h0);

    // Autoreload, COMPARE=2, CTRL=en|autoreload|ie
    wr(A_COMPARE, 32'd2);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    for (int i = 1; i <= 24; i++) begin
      step(1);
      rd_chk($sformatf("auto_count_e%0d", i), A_COUNT, 32'((i / 4) % 3));
      chk($sformatf("auto_irq_e%0d", i), {31'd0, irq}, (i >= 12) ? 32'd1 : 32'd0);
    end
    // Clear on a non-tick edge
    wr(A_STATUS, 32'h2);
    chk("clr_irq", {31'd0, irq}, 32'h0);
    rd_chk("clr_status", A_STATUS, 32'h0);
    // Clear on the edge where COUNT==2 ticks: set wins
    step(10);
    wr(A_STATUS, 32'h2);
    chk("clr_vs_set_irq", {31'd0, irq}, 32'h1);
    rd_chk("clr_vs_set_status", A_STATUS, 32'h2);
    rd_chk("clr_vs_set_count", A_COUNT, 32'h0);
    // CPU write to COUNT on a tick edge
    step(3);
    wr(A_COUNT, 32'd100);
    rd_chk("count_write_on_tick", A_COUNT, 32'd100);

    // Wrap 0xFFFFFFFF -> 0 with COMPARE=5, no flag
    wr(A_CTRL, 32'h0);
    wr(A_COMPARE, 32'd5);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_STATUS, 32'h2);
    wr(A_CTRL, 32'h1);
    step(3);
    rd_chk("wrap_before", A_COUNT, 32'hFFFF_FFFF);
    step(1);
    rd_chk("wrap_after", A_COUNT, 32'h0);
    rd_chk("wrap_status", A_STATUS, 32'h0);

    // Async reset between edges with the interrupt active
    wr(A_CTRL, 32'h0);
    wr(A_COMPARE, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_STATUS, 32'h2);
    wr(A_CTRL, 32'h5);
    step(5);
    chk("pre_rst_irq", {31'd0, irq}, 32'h1);
    chk("pre_rst_leds", {24'd0, leds}, 32'h0000_00A5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_leds", {24'd0, leds}, 32'h0);
    chk("async_rst_irq", {31'd0, irq}, 32'h0);
    rd_chk("async_rst_count", A_COUNT, 32'h0);
    rd_chk("async_rst_compare", A_COMPARE, 32'hFFFF_FFFF);
    rd_chk("async_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("async_rst_status", A_STATUS, 32'h0);
    reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
